// File: rtl/spi_xfer_seq_pkg.sv
// spi_xfer_seq shared definitions.
// wb_spi register map, sequencer states and the access descriptor.
package spi_xfer_seq_pkg;

  localparam logic [7:0] REG_DATA = 8'h00;
  localparam logic [7:0] REG_STAT = 8'h04;
  localparam logic [7:0] REG_CS   = 8'h08;
  localparam logic [7:0] REG_DIV  = 8'h0C;

  localparam int STAT_RUN = 0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CS_WR,
    ST_DATA_WR,
    ST_POLL,
    ST_DATA_RD,
    ST_PUSH,
    ST_CS_REL
  } state_t;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [7:0] off;
    logic [7:0] dat;
  } acc_t;

  function automatic logic [31:0] reg_adr(
    input logic [31:0] base,
    input logic [7:0]  off
  );
    return base + {24'h0, off};
  endfunction

endpackage

// File: rtl/spi_xfer_seq_if.sv
// Wishbone classic bus between the sequencer and wb_spi.
// Signal names match the wb_spi master-side port list.
interface spi_xfer_seq_if;

  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic        m_ack_i;

  modport master (
    output m_adr_o, m_dat_o, m_sel_o,
    output m_cyc_o, m_stb_o, m_we_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_sel_o,
    input  m_cyc_o, m_stb_o, m_we_o,
    output m_dat_i, m_ack_i
  );

endinterface

// File: rtl/spi_xfer_seq_sync_fifo.sv
// Synchronous FWFT FIFO, power-of-two depth.
// Pop while empty and push while full (without pop) are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (cnt != '0);
  assign do_push  = push && ((cnt != (AW+1)'(DEPTH)) || do_pop);
  assign valid    = (cnt != '0);
  assign pop_data = mem[rp];
  assign level    = cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// Byte-command sequencer driving the wb_spi register file.
// Each byte: optional CS write, data write, status poll, data read.
import spi_xfer_seq_pkg::*;

module spi_xfer_seq #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter logic [7:0]  DIVISOR  = 8'h04,
  parameter logic [3:0]  CS_IDLE  = 4'hF,
  parameter int          RX_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_data,
  input  logic [3:0]                cmd_cs,
  input  logic                      cmd_last,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [7:0]                rx_data,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      busy,
  spi_xfer_seq_if.master            wb
);

  localparam int LW = $clog2(RX_DEPTH) + 1;

  state_t        state;
  state_t        state_n;
  acc_t          acc;
  logic          stb_q;
  logic          done_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [7:0]    rd_q;
  logic [7:0]    data_l;
  logic [3:0]    cs_l;
  logic          last_l;
  logic [3:0]    cs_q;
  logic          ready_q;
  logic          busy_q;
  logic          accept;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_n;
  logic          unused_dat;

  assign accept  = cmd_valid && ready_q;
  assign push    = (state == ST_PUSH);
  assign pop     = rx_valid && rx_ready;
  assign level_n = rx_level + LW'(push) - LW'(pop);

  assign unused_dat = ^wb.m_dat_i[31:8];

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_n;
  end

  // done_q marks the idle cycle after an ack; transitions happen there.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_INIT:    if (done_q) state_n = ST_IDLE;
      ST_IDLE:
        if (accept)
          state_n = (cmd_cs != cs_q) ? ST_CS_WR : ST_DATA_WR;
      ST_CS_WR:   if (done_q) state_n = ST_DATA_WR;
      ST_DATA_WR: if (done_q) state_n = ST_POLL;
      ST_POLL:
        if (done_q && !rd_q[STAT_RUN]) state_n = ST_DATA_RD;
      ST_DATA_RD: if (done_q) state_n = ST_PUSH;
      ST_PUSH:    state_n = last_l ? ST_CS_REL : ST_IDLE;
      ST_CS_REL:  if (done_q) state_n = ST_IDLE;
      default:    state_n = ST_INIT;
    endcase
  end

  always_comb begin
    acc = '0;
    unique case (state)
      ST_INIT:    acc = '{1'b1, 1'b1, REG_DIV, DIVISOR};
      ST_CS_WR:   acc = '{1'b1, 1'b1, REG_CS, {4'h0, cs_l}};
      ST_DATA_WR: acc = '{1'b1, 1'b1, REG_DATA, data_l};
      ST_POLL:    acc = '{1'b1, 1'b0, REG_STAT, 8'h00};
      ST_DATA_RD: acc = '{1'b1, 1'b0, REG_DATA, 8'h00};
      ST_CS_REL:  acc = '{1'b1, 1'b1, REG_CS, {4'h0, CS_IDLE}};
      default:    acc = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      data_l  <= '0;
      cs_l    <= CS_IDLE;
      last_l  <= 1'b0;
      cs_q    <= CS_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_n == ST_IDLE)
                 && (level_n < LW'(RX_DEPTH));
      busy_q  <= (state_n != ST_IDLE);
      if (accept) begin
        data_l <= cmd_data;
        cs_l   <= cmd_cs;
        last_l <= cmd_last;
      end
      // Never re-raise stb in the cycle after an ack (stale wb_spi ack).
      if (stb_q) begin
        if (wb.m_ack_i) begin
          stb_q  <= 1'b0;
          done_q <= 1'b1;
          rd_q   <= wb.m_dat_i[7:0];
        end
      end else if (done_q) begin
        done_q <= 1'b0;
        if (state == ST_CS_WR)  cs_q <= cs_l;
        if (state == ST_CS_REL) cs_q <= CS_IDLE;
      end else if (acc.req) begin
        stb_q <= 1'b1;
        we_q  <= acc.we;
        adr_q <= reg_adr(BASE_ADR, acc.off);
        dat_q <= {24'h0, acc.dat};
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign wb.m_cyc_o = stb_q;
  assign wb.m_stb_o = stb_q;
  assign wb.m_we_o  = we_q;
  assign wb.m_adr_o = adr_q;
  assign wb.m_dat_o = dat_q;
  assign wb.m_sel_o = {4{stb_q}};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rd_q),
    .pop       (pop),
    .pop_data  (rx_data),
    .valid     (rx_valid),
    .level     (rx_level)
  );

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Scoreboard bench for spi_xfer_seq against a loopback wb_spi model.
// Bus accesses and RX bytes are checked by independent monitors.
module tb_spi_xfer_seq;

  typedef logic [40:0] ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_cs = 4'h0;
  logic       cmd_last = 1'b0;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [4:0] rx_level;
  logic       busy;

  always #5 clk = ~clk;

  spi_xfer_seq_if wb_bus ();

  spi_xfer_seq dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_cs    (cmd_cs),
    .cmd_last  (cmd_last),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_level  (rx_level),
    .busy      (busy),
    .wb        (wb_bus)
  );

  // wb_spi model: registered ack, MISO looped to MOSI.
  logic       s_ack;
  logic       s_run;
  int         s_cnt;
  logic [7:0] s_shift;

  always @(posedge clk) begin
    if (!reset) begin
      s_ack   <= 1'b0;
      s_run   <= 1'b0;
      s_cnt   <= 0;
      s_shift <= 8'h00;
    end else begin
      s_ack <= wb_bus.m_cyc_o && wb_bus.m_stb_o;
      if (s_run) begin
        if (s_cnt == 0) s_run <= 1'b0;
        else            s_cnt <= s_cnt - 1;
      end
      if (wb_bus.m_stb_o && s_ack && wb_bus.m_we_o
          && wb_bus.m_adr_o[7:0] == 8'h00) begin
        s_shift <= wb_bus.m_dat_o[7:0];
        s_run   <= 1'b1;
        s_cnt   <= 6;
      end
    end
  end

  assign wb_bus.m_ack_i = s_ack;
  assign wb_bus.m_dat_i =
    (wb_bus.m_adr_o[7:0] == 8'h04) ? {31'h0, s_run} :
    (wb_bus.m_adr_o[7:0] == 8'h00) ? {24'h0, s_shift} : 32'h0;

  ev_t        exp_bus[$];
  logic [7:0] exp_rx[$];
  int         checks = 0;
  int         errors = 0;
  int         stat_reads = 0;
  int         data_wrs = 0;
  logic [3:0] tb_cs = 4'hF;
  logic       prev_ack = 1'b0;
  ev_t        got_ev;
  ev_t        want_ev;
  logic [7:0] want_rx;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t ev(input logic we,
                             input logic [7:0] off,
                             input logic [7:0] d);
    return {we, 24'h0, off, d};
  endfunction

  // Bus monitor: gap after ack, sel, and access order.
  always @(negedge clk) begin
    if (!reset) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) check("stb_gap", wb_bus.m_stb_o, 0);
      if (wb_bus.m_stb_o) check("sel", wb_bus.m_sel_o, 4'hF);
      prev_ack = wb_bus.m_stb_o && s_ack;
      if (wb_bus.m_stb_o && s_ack) begin
        if (!wb_bus.m_we_o && wb_bus.m_adr_o == 32'h4) begin
          stat_reads++;
        end else begin
          got_ev = {wb_bus.m_we_o, wb_bus.m_adr_o,
                    wb_bus.m_we_o ? wb_bus.m_dat_o[7:0] : 8'h00};
          if (wb_bus.m_we_o && wb_bus.m_adr_o == 32'h0)
            data_wrs++;
          if (exp_bus.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: got %0h expected none",
                     got_ev);
          end else begin
            want_ev = exp_bus.pop_front();
            check("bus_access", got_ev, want_ev);
          end
        end
      end
    end
  end

  // RX monitor.
  always @(negedge clk) begin
    if (reset && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        want_rx = exp_rx.pop_front();
        check("rx_data", rx_data, want_rx);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d,
                          input logic [3:0] cs,
                          input logic last);
    if (cs != tb_cs) begin
      exp_bus.push_back(ev(1'b1, 8'h08, {4'h0, cs}));
      tb_cs = cs;
    end
    exp_bus.push_back(ev(1'b1, 8'h00, d));
    exp_bus.push_back(ev(1'b0, 8'h00, 8'h00));
    exp_rx.push_back(d);
    if (last) begin
      exp_bus.push_back(ev(1'b1, 8'h08, 8'h0F));
      tb_cs = 4'hF;
    end
  endtask

  task automatic drive(input logic [7:0] d,
                       input logic [3:0] cs,
                       input logic last);
    int n;
    cmd_data  = d;
    cmd_cs    = cs;
    cmd_last  = last;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got timeout expected accept");
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic [3:0] cs,
                      input logic last);
    push_exp(d, cs, last);
    drive(d, cs, last);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || busy) && n < 5000) begin
      step();
      n++;
    end
    check(name, (n >= 5000), 0);
  endtask

  initial begin
    int n;
    int hi;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_ctl",
          {wb_bus.m_cyc_o, wb_bus.m_stb_o, wb_bus.m_we_o}, 0);
    check("rst_adr_dat", {wb_bus.m_adr_o, wb_bus.m_dat_o}, 0);
    check("rst_sel", wb_bus.m_sel_o, 0);

    exp_bus.push_back(ev(1'b1, 8'h0C, 8'h04));
    reset = 1'b1;
    step();
    check("busy_init", busy, 1);
    wait_idle("init_done");
    check("ready_idle", cmd_ready, 1);

    rx_ready = 1'b1;
    send(8'hA5, 4'hE, 1'b1);
    wait_idle("single_done");
    repeat (3) step();
    check("single_rx_drained", exp_rx.size(), 0);

    rx_ready = 1'b0;
    send(8'h11, 4'hE, 1'b0);
    send(8'h22, 4'hE, 1'b0);
    send(8'h33, 4'hE, 1'b1);
    wait_idle("frame_done");
    check("frame_level", rx_level, 3);
    check("frame_head", rx_data, 8'h11);
    rx_ready = 1'b1;
    repeat (5) step();
    rx_ready = 1'b0;
    check("frame_rx_drained", exp_rx.size(), 0);

    for (int i = 0; i < 16; i++)
      send(8'h40 + 8'(i), 4'hF, 1'b0);
    wait_idle("fill_done");
    check("full_level", rx_level, 16);
    push_exp(8'h99, 4'hF, 1'b0);
    cmd_data  = 8'h99;
    cmd_cs    = 4'hF;
    cmd_last  = 1'b0;
    cmd_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) hi++;
      step();
    end
    check("full_ready_low", hi, 0);
    check("full_no_access", exp_bus.size(), 2);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    drive(8'h99, 4'hF, 1'b0);
    wait_idle("refill_done");
    check("refill_level", rx_level, 16);
    rx_ready = 1'b1;
    repeat (40) step();
    check("full_rx_drained", exp_rx.size(), 0);
    check("empty_level", rx_level, 0);

    rx_ready = 1'b0;
    send(8'h3C, 4'hF, 1'b0);
    wait_idle("pre_rst_done");
    check("pre_rst_level", rx_level, 1);
    exp_bus.push_back(ev(1'b1, 8'h00, 8'h77));
    drive(8'h77, 4'hF, 1'b0);
    n = 0;
    while (!(wb_bus.m_stb_o && !wb_bus.m_we_o
             && wb_bus.m_adr_o == 32'h4) && n < 2000) begin
      step();
      n++;
    end
    check("poll_seen", (n >= 2000), 0);
    reset = 1'b0;
    step();
    check("rst_mid_stb", wb_bus.m_stb_o, 0);
    check("rst_mid_cyc", wb_bus.m_cyc_o, 0);
    check("rst_mid_level", rx_level, 0);
    check("rst_mid_valid", rx_valid, 0);
    check("rst_mid_ready", cmd_ready, 0);
    check("rst_mid_bus_q", exp_bus.size(), 0);
    exp_rx.delete();
    tb_cs = 4'hF;
    exp_bus.push_back(ev(1'b1, 8'h0C, 8'h04));
    step();
    reset = 1'b1;
    step();
    check("reinit_busy", busy, 1);
    wait_idle("reinit_done");
    check("reinit_ready", cmd_ready, 1);

    rx_ready = 1'b1;
    send(8'h5A, 4'h7, 1'b1);
    wait_idle("final_done");
    repeat (5) step();
    check("final_rx_drained", exp_rx.size(), 0);
    check("poll_repeat", (stat_reads > data_wrs), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
